// File: rtl/lcd_char_writer_if.sv
// Character/clear request and LCD bus bundle for lcd_char_writer.
// slave = the writer, master = the upstream driver / bus observer.
interface lcd_char_writer_if;
    logic [7:0] i_char;
    logic       i_char_vld;
    logic       i_clear;
    logic       o_busy;
    logic       o_lcd_e;
    logic       o_lcd_rs;
    logic       o_lcd_rw;
    logic [7:0] o_lcd_data;
    logic [3:0] o_col;
    logic       o_line;

    modport slave (
        input  i_char, i_char_vld, i_clear,
        output o_busy, o_lcd_e, o_lcd_rs, o_lcd_rw, o_lcd_data, o_col, o_line
    );
    modport master (
        output i_char, i_char_vld, i_clear,
        input  o_busy, o_lcd_e, o_lcd_rs, o_lcd_rw, o_lcd_data, o_col, o_line
    );
endinterface

// File: rtl/lcd_char_writer.sv
// HD44780 16x2 character writer: power-on init, cursor tracking with wrap, clear.
// Option LCD_BLANK_CLEAR_EN: a 0x20 character strobe acts as a clear request.
module lcd_char_writer #(
    parameter int PWR_WAIT = 750000,
    parameter int E_PULSE  = 25,
    parameter int CMD_WAIT = 2500,
    parameter int CLR_WAIT = 100000
) (
    input  logic              clk,
    input  logic              rst,
    lcd_char_writer_if.slave  bus
);
    localparam int MAXW0 = (PWR_WAIT > CLR_WAIT) ? PWR_WAIT : CLR_WAIT;
    localparam int MAXW1 = (CMD_WAIT > E_PULSE) ? CMD_WAIT : E_PULSE;
    localparam int MAXW  = (MAXW0 > MAXW1) ? MAXW0 : MAXW1;
    localparam int CNT_W = (MAXW > 1) ? $clog2(MAXW) : 1;

    localparam logic [CNT_W-1:0] PWR_M1 = CNT_W'(PWR_WAIT - 1);
    localparam logic [CNT_W-1:0] EP_M1  = CNT_W'(E_PULSE - 1);
    localparam logic [CNT_W-1:0] CMD_M1 = CNT_W'(CMD_WAIT - 1);
    localparam logic [CNT_W-1:0] CLR_M1 = CNT_W'(CLR_WAIT - 1);

    typedef enum logic [2:0] {S_PWR, S_INIT, S_IDLE, S_ADDR, S_DATA, S_CLR} state_t;
    typedef enum logic [1:0] {P_SETUP, P_PULSE, P_WAIT} phase_t;

    state_t           r_state, w_nx_state;
    phase_t           r_ph, w_nx_ph;
    logic [CNT_W-1:0] r_cnt, w_nx_cnt;
    logic [1:0]       r_idx, w_nx_idx;
    logic             r_rs, w_nx_rs;
    logic [7:0]       r_data, w_nx_data;
    logic [7:0]       r_char, w_nx_char;
    logic [3:0]       r_col, w_nx_col;
    logic             r_line, w_nx_line;

    logic             w_in_txn, w_done, w_clr_req;
    logic [CNT_W-1:0] w_wait_m1;

    function automatic logic [7:0] init_cmd(input logic [1:0] idx);
        case (idx)
            2'd0:    return 8'h38;
            2'd1:    return 8'h0C;
            2'd2:    return 8'h01;
            default: return 8'h06;
        endcase
    endfunction

`ifdef LCD_BLANK_CLEAR_EN
    assign w_clr_req = bus.i_clear | (bus.i_char_vld && bus.i_char == 8'h20);
`else
    assign w_clr_req = bus.i_clear;
`endif

    assign w_in_txn  = (r_state != S_PWR) && (r_state != S_IDLE);
    assign w_done    = w_in_txn && (r_ph == P_WAIT) && (r_cnt == '0);
    // Only the clear command needs the long settle time.
    assign w_wait_m1 = (!r_rs && r_data == 8'h01) ? CLR_M1 : CMD_M1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_PWR;
            r_ph    <= P_SETUP;
            r_cnt   <= PWR_M1;
            r_idx   <= '0;
            r_rs    <= 1'b0;
            r_data  <= '0;
            r_char  <= '0;
            r_col   <= '0;
            r_line  <= 1'b0;
        end else begin
            r_state <= w_nx_state;
            r_ph    <= w_nx_ph;
            r_cnt   <= w_nx_cnt;
            r_idx   <= w_nx_idx;
            r_rs    <= w_nx_rs;
            r_data  <= w_nx_data;
            r_char  <= w_nx_char;
            r_col   <= w_nx_col;
            r_line  <= w_nx_line;
        end
    end

    always_comb begin
        w_nx_state = r_state;
        w_nx_ph    = r_ph;
        w_nx_cnt   = r_cnt;
        w_nx_idx   = r_idx;
        w_nx_rs    = r_rs;
        w_nx_data  = r_data;
        w_nx_char  = r_char;
        w_nx_col   = r_col;
        w_nx_line  = r_line;

        if (w_in_txn) begin
            case (r_ph)
                P_SETUP: begin
                    w_nx_ph  = P_PULSE;
                    w_nx_cnt = EP_M1;
                end
                P_PULSE: begin
                    if (r_cnt == '0) begin
                        w_nx_ph  = P_WAIT;
                        w_nx_cnt = w_wait_m1;
                    end else begin
                        w_nx_cnt = r_cnt - 1'b1;
                    end
                end
                default: begin
                    if (r_cnt != '0) w_nx_cnt = r_cnt - 1'b1;
                end
            endcase
        end

        // Starting a transaction overrides the phase sequencing above.
        case (r_state)
            S_PWR: begin
                if (r_cnt == '0) begin
                    w_nx_state = S_INIT;
                    w_nx_ph    = P_SETUP;
                    w_nx_idx   = 2'd0;
                    w_nx_rs    = 1'b0;
                    w_nx_data  = init_cmd(2'd0);
                end else begin
                    w_nx_cnt = r_cnt - 1'b1;
                end
            end
            S_INIT: begin
                if (w_done) begin
                    if (r_idx == 2'd3) begin
                        w_nx_state = S_IDLE;
                    end else begin
                        w_nx_idx  = r_idx + 2'd1;
                        w_nx_ph   = P_SETUP;
                        w_nx_data = init_cmd(r_idx + 2'd1);
                    end
                end
            end
            S_IDLE: begin
                if (w_clr_req) begin
                    w_nx_state = S_CLR;
                    w_nx_ph    = P_SETUP;
                    w_nx_rs    = 1'b0;
                    w_nx_data  = 8'h01;
                end else if (bus.i_char_vld) begin
                    w_nx_state = S_ADDR;
                    w_nx_char  = bus.i_char;
                    w_nx_ph    = P_SETUP;
                    w_nx_rs    = 1'b0;
                    w_nx_data  = {1'b1, r_line, 2'b00, r_col};
                end
            end
            S_ADDR: begin
                if (w_done) begin
                    w_nx_state = S_DATA;
                    w_nx_ph    = P_SETUP;
                    w_nx_rs    = 1'b1;
                    w_nx_data  = r_char;
                end
            end
            S_DATA: begin
                if (w_done) begin
                    w_nx_state = S_IDLE;
                    if (r_col == 4'd15) begin
                        w_nx_col  = 4'd0;
                        w_nx_line = ~r_line;
                    end else begin
                        w_nx_col = r_col + 4'd1;
                    end
                end
            end
            S_CLR: begin
                if (w_done) begin
                    w_nx_state = S_IDLE;
                    w_nx_col   = 4'd0;
                    w_nx_line  = 1'b0;
                end
            end
            default: w_nx_state = S_PWR;
        endcase
    end

    assign bus.o_busy     = (r_state != S_IDLE);
    assign bus.o_lcd_e    = w_in_txn && (r_ph == P_PULSE);
    assign bus.o_lcd_rs   = r_rs;
    assign bus.o_lcd_rw   = 1'b0;
    assign bus.o_lcd_data = r_data;
    assign bus.o_col      = r_col;
    assign bus.o_line     = r_line;
endmodule

// File: tb/tb_lcd_char_writer.sv
// Randomized bench for lcd_char_writer: bus monitor plus a cursor/transaction
// reference model built from the LCD addressing rules.
module tb_lcd_char_writer;
    localparam int PW  = 20;
    localparam int EP  = 2;
    localparam int CW  = 4;
    localparam int CLW = 10;

    typedef struct {
        logic       rs;
        logic [7:0] d;
        int         cyc;
    } txn_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    lcd_char_writer_if bus();

    lcd_char_writer #(
        .PWR_WAIT(PW), .E_PULSE(EP), .CMD_WAIT(CW), .CLR_WAIT(CLW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   last_fall = 0;
    int   width   = 0;
    int   pos     = 0;  // cursor as linear index 0..31
    logic prev_e  = 1'b0;
    logic [8:0] rise_v;
    txn_t mon_q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Bus monitor: records each E rise and checks pulse width and hold.
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (rst) begin
            prev_e = 1'b0;
            width  = 0;
        end else begin
            if (bus.o_lcd_e) begin
                if (!prev_e) begin
                    mon_q.push_back('{rs: bus.o_lcd_rs, d: bus.o_lcd_data, cyc: cyc});
                    rise_v = {bus.o_lcd_rs, bus.o_lcd_data};
                    chk("rw_low", bus.o_lcd_rw, 0);
                end
                width++;
            end else if (prev_e) begin
                chk("e_width", width, EP);
                chk("bus_hold", {bus.o_lcd_rs, bus.o_lcd_data}, rise_v);
                width     = 0;
                last_fall = cyc;
            end
            prev_e = bus.o_lcd_e;
        end
    end

    function automatic logic [7:0] icmd(input int i);
        case (i)
            0:       return 8'h38;
            1:       return 8'h0C;
            2:       return 8'h01;
            default: return 8'h06;
        endcase
    endfunction

    task automatic wait_idle(output int idle_cyc);
        bit seen = 0;
        idle_cyc = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk); #1;
            if (!bus.o_busy) begin
                seen = 1;
                idle_cyc = cyc;
                break;
            end
        end
        if (!seen) chk("idle_timeout", 0, 1);
    endtask

    task automatic do_reset(output int rel);
        rst = 1'b1;
        bus.i_char = 8'h00; bus.i_char_vld = 1'b0; bus.i_clear = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_e", bus.o_lcd_e, 0);
        chk("rst_rs", bus.o_lcd_rs, 0);
        chk("rst_rw", bus.o_lcd_rw, 0);
        chk("rst_data", bus.o_lcd_data, 8'h00);
        chk("rst_busy", bus.o_busy, 1);
        chk("rst_col", bus.o_col, 0);
        chk("rst_line", bus.o_line, 0);
        @(negedge clk); #1;
        rel = cyc;
        rst = 1'b0;
        mon_q.delete();
        pos = 0;
    endtask

    task automatic chk_init(input int rel);
        int idle;
        wait_idle(idle);
        chk("init_count", mon_q.size(), 4);
        for (int i = 0; i < 4 && i < mon_q.size(); i++) begin
            chk("init_rs", mon_q[i].rs, 0);
            chk("init_data", mon_q[i].d, icmd(i));
            if (i > 0)
                chk("init_gap", mon_q[i].cyc - mon_q[i-1].cyc, 1 + EP + ((i == 3) ? CLW : CW));
        end
        if (mon_q.size() > 0) chk("pwr_wait", mon_q[0].cyc - rel, PW + 1);
        chk("init_busy_fall", idle - last_fall, CW);
        chk("init_col", bus.o_col, 0);
        chk("init_line", bus.o_line, 0);
        mon_q.delete();
    endtask

    // kind: 0 char, 1 clear, 2 clear together with char
    task automatic do_op(input int kind, input logic [7:0] c, input bit junk);
        int   s, idle, dur, lat;
        bit   is_clr;
        txn_t exp_q[$];
        is_clr = (kind != 0);
`ifdef LCD_BLANK_CLEAR_EN
        if (c == 8'h20) is_clr = 1;
`endif
        if (is_clr) begin
            exp_q.push_back('{rs: 1'b0, d: 8'h01, cyc: 0});
            dur = 1 + EP + CLW;
            lat = 2;
        end else begin
            exp_q.push_back('{rs: 1'b0, d: 8'h80 + ((pos >= 16) ? 8'h40 : 8'h00) + 8'(pos % 16), cyc: 0});
            exp_q.push_back('{rs: 1'b1, d: c, cyc: 0});
            dur = 2 * (1 + EP + CW);
            lat = 3 + EP + CW;
        end
        chk("pre_idle", bus.o_busy, 0);
        mon_q.delete();
        s = cyc;
        bus.i_char = c;
        bus.i_char_vld = (kind != 1);
        bus.i_clear = (kind != 0);
        @(negedge clk); #1;
        bus.i_char_vld = 1'b0; bus.i_clear = 1'b0;
        if (junk) begin
            repeat ($urandom_range(0, 4)) @(negedge clk);
            #1;
            chk("junk_while_busy", bus.o_busy, 1);
            bus.i_char = 8'($urandom_range(8'h21, 8'h7E));
            bus.i_char_vld = 1'b1;
            bus.i_clear = 1'($urandom_range(0, 1));
            @(negedge clk); #1;
            bus.i_char_vld = 1'b0; bus.i_clear = 1'b0;
        end
        wait_idle(idle);
        chk("busy_len", idle - s, dur + 1);
        chk("txn_count", mon_q.size(), exp_q.size());
        if (mon_q.size() == exp_q.size()) begin
            foreach (exp_q[i]) begin
                chk("txn_rs", mon_q[i].rs, exp_q[i].rs);
                chk("txn_data", mon_q[i].d, exp_q[i].d);
            end
            chk("latency", mon_q[exp_q.size()-1].cyc - s, lat);
        end
        pos = is_clr ? 0 : (pos + 1) % 32;
        chk("col", bus.o_col, pos % 16);
        chk("line", bus.o_line, pos / 16);
    endtask

    initial begin
        int  rel;
        bit  found;
        int  k;
        logic [7:0] c;

        do_reset(rel);
        chk_init(rel);

        do_op(0, 8'h35, 0);

        // enough characters to cross into line 1 and wrap back home
        for (int i = 0; i < 40; i++)
            do_op(0, 8'($urandom_range(8'h21, 8'h7E)), 1'($urandom_range(0, 1)));

        do_op(0, 8'h20, 0);
        do_op(2, 8'h41, 0);
        do_op(1, 8'h00, 1);

        for (int i = 0; i < 30; i++) begin
            k = $urandom_range(0, 9);
            c = 8'($urandom_range(8'h20, 8'h7E));
            do_op((k < 7) ? 0 : ((k < 9) ? 1 : 2), c, 1'($urandom_range(0, 1)));
        end

        // reset in the middle of a data write
        do_op(0, 8'h51, 0);
        bus.i_char = 8'h52; bus.i_char_vld = 1'b1;
        @(negedge clk); #1;
        bus.i_char_vld = 1'b0;
        found = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk); #1;
            if (bus.o_lcd_e && bus.o_lcd_rs) begin
                found = 1;
                break;
            end
        end
        chk("data_e_seen", found, 1);
        rst = 1'b1;
        #1;
        chk("abort_e", bus.o_lcd_e, 0);
        chk("abort_busy", bus.o_busy, 1);
        chk("abort_col", bus.o_col, 0);
        do_reset(rel);
        chk_init(rel);
        do_op(0, 8'h35, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
